// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor, DIGIT bits per clock over WIDTH/DIGIT cycles, valid/ready on both sides.
// Subtract mode is present only when SEQ_ADDSUB_SUB_EN is defined; otherwise sub is ignored.
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int SW = DIGIT + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] a_sr, b_sr, b_ld;
  logic [CW-1:0] cnt;
  logic carry, cy_ld, msb_cin, last;
  logic [DIGIT:0] slice;
`ifdef SEQ_ADDSUB_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign cy_ld = c_in ^ sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_ld = b;
  assign cy_ld = c_in;
`endif
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign last = cnt == CW'(N - 1);
  assign slice = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + SW'(carry);
  // carry into the MSB recovered from the top slice's sum bit, no second adder needed
  assign msb_cin = slice[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      sum <= '0;
      carry <= 1'b0;
      cnt <= '0;
      c_out <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_sr <= a;
        b_sr <= b_ld;
        carry <= cy_ld;
        cnt <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      a_sr <= a_sr >> DIGIT;
      b_sr <= b_sr >> DIGIT;
      sum <= (sum >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
      carry <= slice[DIGIT];
      cnt <= cnt + CW'(1);
      if (last) begin
        c_out <= slice[DIGIT];
        ovf <= msb_cin ^ slice[DIGIT];
        state <= DONE;
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule
